imem_fetch_ctrl: RTL and testbench

//  Sequencer and single-port owner for memoriaInstrucao (word-addressed, combinational read).

---
 rtl/imem_fetch_ctrl_pkg.sv | 18 +
 rtl/imem_fetch_ctrl_if.sv | 29 ++
 rtl/imem_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Package: imem_fetch_ctrl_pkg
// Shared sizes, the halt sentinel and FSM state encodings for the instruction memory
// fetch controller and its bus interface.
package imem_fetch_ctrl_pkg;

    localparam int unsigned WORD_SIZE     = 32;
    localparam int unsigned INST_MEM_SIZE = 256;
    localparam int unsigned ADDR_W        = 8;

    localparam logic [WORD_SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(INST_MEM_SIZE - 1);

    // FSM encodings kept as plain constants so legacy users of the shared header still match.
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Interface: imem_fetch_ctrl_if
// Loader handshake plus the single instruction-memory port owned by the fetch controller.
//   load_valid/load_data/load_last : loader word offer, load_ready : controller accepts
//   mem_we/mem_addr/mem_wdata      : memory write/address port, mem_rdata : same-cycle read
// modport master : the controller (owns the memory port, consumes loader words)
// modport slave  : the environment (loader source and the memory itself)
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic                 load_valid;
    logic [WORD_SIZE-1:0] load_data;
    logic                 load_last;
    logic                 load_ready;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport master (
        input  load_valid, load_data, load_last, mem_rdata,
        output load_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output load_valid, load_data, load_last, mem_rdata,
        input  load_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// Module: imem_fetch_ctrl
// Sequencer and single-port owner of the instruction memory. In LOAD it streams loader words
// into memory from address 0; in RUN it drives the fetch PC and registers each fetched word
// for decode, honouring stall and redirect; fetching the halt sentinel parks it in HALT.
// Ports:
//   clk_i, rst_ni   : clock and synchronous active-low reset
//   bus_io          : loader handshake and memory port (master side)
//   stall_i         : hold fetch state
//   redirect_i      : taken branch/jump, redirect_pc_i is the target word address
//   pc_o, instr_o   : word address and registered instruction presented to decode
//   instr_valid_o   : instr_o is valid
//   load_count_o    : words written by the last load
//   halted_o        : halt sentinel was fetched
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    imem_fetch_ctrl_if.master       bus_io,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [ADDR_W-1:0]       redirect_pc_i,
    output logic [ADDR_W-1:0]       pc_o,
    output logic [WORD_SIZE-1:0]    instr_o,
    output logic                    instr_valid_o,
    output logic [ADDR_W:0]         load_count_o,
    output logic                    halted_o
);

    logic [1:0]           state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic [ADDR_W:0]      load_count_q, load_count_d;

    logic                 load_ready;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        load_count_d  = load_count_q;
        load_ready    = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = fetch_pc_q;

        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                mem_addr   = wr_ptr_q;
                mem_we     = bus_io.load_valid;
                if (bus_io.load_valid) begin
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    load_count_d = {1'b0, wr_ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
                    // A full memory ends the load even without load_last; no wrap.
                    if (bus_io.load_last || (wr_ptr_q == LAST_ADDR)) begin
                        state_d    = ST_RUN;
                        fetch_pc_d = '0;
                    end
                end
            end
            ST_RUN: begin
                if (redirect_i) begin
                    // Redirect wins over stall; the word at the old fetch_pc is dropped.
                    fetch_pc_d    = redirect_pc_i;
                    instr_valid_d = 1'b0;
                end else if (!stall_i) begin
                    if (bus_io.mem_rdata == HALT_WORD) begin
                        state_d       = ST_HALT;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = bus_io.mem_rdata;
                        pc_d          = fetch_pc_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = fetch_pc_q + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // Everything frozen until reset.
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= '0;
            fetch_pc_q    <= '0;
            pc_q          <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            load_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            load_count_q  <= load_count_d;
        end
    end

    assign bus_io.load_ready = load_ready;
    assign bus_io.mem_we     = mem_we;
    assign bus_io.mem_addr   = mem_addr;
    assign bus_io.mem_wdata  = bus_io.load_data;

    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = instr_valid_q;
    assign load_count_o  = load_count_q;
    assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: a behavioural memory, directed stimulus that queues the
// expected memory writes and issued instructions, and a negedge monitor that pops and compares.
module tb_imem_fetch_ctrl;
    import imem_fetch_ctrl_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 stall;
    logic                 redirect;
    logic [ADDR_W-1:0]    redirect_pc;
    logic [ADDR_W-1:0]    pc;
    logic [WORD_SIZE-1:0] instr;
    logic                 instr_valid;
    logic [ADDR_W:0]      load_count;
    logic                 halted;

    int checks = 0;
    int errors = 0;

    ent_t exp_wr[$];
    ent_t exp_fe[$];
    ent_t got_wr;
    ent_t got_fe;

    logic [WORD_SIZE-1:0] mem [INST_MEM_SIZE];

    logic [WORD_SIZE-1:0] a_words [3] = '{32'h2001_0005, 32'h2002_0003, 32'h0022_1820};
    logic [WORD_SIZE-1:0] c_words [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                          32'h4444_4444, 32'hFFFF_FFFF};

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus_io        (bus),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .load_count_o  (load_count),
        .halted_o      (halted)
    );

    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, write on the rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int a, input logic [WORD_SIZE-1:0] d);
        ent_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_fe(input int a, input logic [WORD_SIZE-1:0] d);
        ent_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_fe.push_back(e);
    endtask

    // Monitor: every write and every cycle with instr_valid must match the queue head.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got write %0h@%0h expected no write",
                         bus.mem_wdata, bus.mem_addr);
            end else begin
                got_wr = exp_wr.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(got_wr.addr));
                chk("wr_data", 64'(bus.mem_wdata), 64'(got_wr.data));
            end
        end
        if (instr_valid === 1'b1) begin
            if (exp_fe.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fe_unexpected: got instr %0h pc %0h expected no issue", instr, pc);
            end else begin
                got_fe = exp_fe.pop_front();
                chk("fe_pc", 64'(pc), 64'(got_fe.addr));
                chk("fe_instr", 64'(instr), 64'(got_fe.data));
            end
        end
    end

    initial begin
        for (int i = 0; i < INST_MEM_SIZE; i++) mem[i] = 32'h5500_0000 | i;
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_last   = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_load_ready", 64'(bus.load_ready), 64'd1);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_load_count", 64'(load_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        rst_n = 1'b1;

        // Three-word load with load_last, then sequential fetch
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = a_words[i];
            bus.load_last  = (i == 2);
            push_wr(i, a_words[i]);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("a_load_count", 64'(load_count), 64'd3);
        chk("a_load_ready", 64'(bus.load_ready), 64'd0);
        chk("a_first_run_invalid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) push_fe(i, a_words[i]);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("a_reset_from_run", 64'(instr_valid), 64'd0);

        // Full 256-word load, auto RUN, ignored 257th word, stall, redirect
        for (int i = 0; i < INST_MEM_SIZE; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'h0A00_0000 | i;
            push_wr(i, 32'h0A00_0000 | i);
            tick();
        end
        bus.load_data = 32'hDEAD_BEEF;
        chk("b_load_ready_full", 64'(bus.load_ready), 64'd0);
        chk("b_load_count_full", 64'(load_count), 64'd256);
        push_fe(0, 32'h0A00_0000);
        tick();
        bus.load_valid = 1'b0;
        push_fe(1, 32'h0A00_0001);
        tick();
        stall = 1'b1;
        push_fe(1, 32'h0A00_0001);
        push_fe(1, 32'h0A00_0001);
        tick();
        tick();
        stall = 1'b0;
        push_fe(2, 32'h0A00_0002);
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        stall       = 1'b1;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("b_redirect_bubble", 64'(instr_valid), 64'd0);
        chk("b_redirect_pc_hold", 64'(pc), 64'd2);
        push_fe(16, 32'h0A00_0010);
        tick();
        push_fe(17, 32'h0A00_0011);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Halt sentinel at address 4
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = c_words[i];
            bus.load_last  = (i == 4);
            push_wr(i, c_words[i]);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("c_load_count", 64'(load_count), 64'd5);
        for (int i = 0; i < 4; i++) push_fe(i, c_words[i]);
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("c_halted", 64'(halted), 64'd1);
        chk("c_halt_invalid", 64'(instr_valid), 64'd0);
        chk("c_halt_pc", 64'(pc), 64'd3);
        chk("c_halt_instr", 64'(instr), 64'h4444_4444);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hBAD0_BAD0;
        tick();
        tick();
        chk("c_halt_sticky", 64'(halted), 64'd1);
        chk("c_halt_pc_frozen", 64'(pc), 64'd3);
        chk("c_halt_load_ready", 64'(bus.load_ready), 64'd0);
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("c_reset_clears_halt", 64'(halted), 64'd0);

        // Reset mid-load restarts at address 0
        for (int i = 0; i < 2; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 32'hAAAA_0000 | i;
            push_wr(i, 32'hAAAA_0000 | i);
            tick();
        end
        bus.load_valid = 1'b0;
        chk("d_mid_load_count", 64'(load_count), 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("d_rst_load_ready", 64'(bus.load_ready), 64'd1);
        chk("d_rst_load_count", 64'(load_count), 64'd0);
        bus.load_valid = 1'b1;
        bus.load_data  = 32'hBBBB_0000;
        bus.load_last  = 1'b1;
        push_wr(0, 32'hBBBB_0000);
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        chk("d_reload_count", 64'(load_count), 64'd1);
        push_fe(0, 32'hBBBB_0000);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("fe_queue_drained", 64'(exp_fe.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
